// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM state encodings and the
// clocks-per-bit divider calculation.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } uart_state_e;

    // Integer clocks per bit; the fractional remainder is dropped.
    function automatic int unsigned calc_div(input int unsigned freq,
                                             input int unsigned rate);
        return freq / rate;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input; both flops take
// RST_VAL while reset is asserted.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: samples each bit at its midpoint using a down-counting
// bit timer, reports good bytes with o_vld and bad stop bits with o_ferr.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned FREQ = 50_000_000,
    parameter int unsigned RATE = 2_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_vld,
    output logic       o_ferr
);

    localparam int unsigned DIV   = calc_div(FREQ, RATE);
    localparam int unsigned TMR_W = $clog2(DIV);
    localparam logic [TMR_W-1:0] HALF_LOAD = TMR_W'(DIV / 2 - 1);
    localparam logic [TMR_W-1:0] FULL_LOAD = TMR_W'(DIV - 1);

    if (DIV < 4) begin : g_div_check
        $error("uart_rx: FREQ/RATE must be at least 4 clocks per bit");
    end

    logic rxs;

    uart_sync2 #(
        .RST_VAL(1'b1)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (i_rx),
        .q    (rxs)
    );

    uart_state_e      state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             vld_q, vld_d;
    logic             ferr_q, ferr_d;
    logic             rxs_prev_q, rxs_prev_d;
    logic             tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            tmr_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            vld_q      <= 1'b0;
            ferr_q     <= 1'b0;
            rxs_prev_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            vld_q      <= vld_d;
            ferr_q     <= ferr_d;
            rxs_prev_q <= rxs_prev_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        data_d     = data_q;
        vld_d      = 1'b0;
        ferr_d     = 1'b0;
        rxs_prev_d = rxs;
        tick       = (tmr_q == '0);

        // The timer only runs while a frame is being sampled.
        if (state_q == ST_START || state_q == ST_DATA || state_q == ST_STOP) begin
            tmr_d = tick ? FULL_LOAD : tmr_q - 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (rxs_prev_q && !rxs) begin
                    state_d = ST_START;
                    tmr_d   = HALF_LOAD;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (!rxs) begin
                        state_d = ST_DATA;
                        idx_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d[idx_q] = rxs;
                    if (idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                // Leave at mid-stop-bit so a back-to-back start edge is caught.
                if (tick) begin
                    if (rxs) begin
                        data_d  = shift_q;
                        vld_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_WAIT_HIGH;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                if (rxs) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign o_data = data_q;
    assign o_vld  = vld_q;
    assign o_ferr = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Randomized scoreboard bench for uart_rx: a serializer drives frames, a
// frame-level model queues expected pulses, a monitor checks what appears.
module tb_uart_rx;

    localparam int FREQ = 50_000_000;
    localparam int RATE = 2_000_000;
    localparam int DIV  = FREQ / RATE;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_rx = 1'b1;
    logic [7:0] o_data;
    logic       o_vld;
    logic       o_ferr;

    always #5 clk = ~clk;

    uart_rx #(
        .FREQ(FREQ),
        .RATE(RATE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .i_rx  (i_rx),
        .o_data(o_data),
        .o_vld (o_vld),
        .o_ferr(o_ferr)
    );

    typedef struct {
        bit         ferr;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] last_good = 8'h00;
    logic [7:0] hold_data = 8'h00;
    int         n_cmp = 0;
    int         n_bad = 0;
    longint     cyc = 0;
    longint     vld_cyc = -1;
    longint     start_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every pulse must match the head of the expectation queue.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (o_vld && o_ferr) check("vld_and_ferr", 1, 0);
            if (o_vld || o_ferr) begin
                if (o_vld) vld_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {o_vld, o_ferr}, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_kind", {o_vld, o_ferr}, e.ferr ? 2'b01 : 2'b10);
                    check("pulse_data", o_data, e.data);
                    hold_data = e.data;
                end
            end else begin
                check("data_hold", o_data, hold_data);
            end
        end
    end

    task automatic drive_bit(input bit v, input int per);
        @(posedge clk);
        #1 i_rx = v;
        repeat (per - 1) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop, input int per);
        if (stop) begin
            last_good = b;
            exp_q.push_back('{ferr: 1'b0, data: b});
        end else begin
            exp_q.push_back('{ferr: 1'b1, data: last_good});
        end
        @(posedge clk);
        #1 i_rx = 1'b0;
        start_cyc = cyc;
        repeat (per - 1) @(posedge clk);
        for (int j = 0; j < 8; j++) drive_bit(b[j], per);
        drive_bit(stop, per);
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            @(posedge clk);
            t++;
        end
        repeat (5) @(posedge clk);
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        repeat (100000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget, pending %0d", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        int         per;
        bit         stop;
        int         periods[3] = '{25, 24, 26};
        int         lat;

        // Outputs while in reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_vld", o_vld, 0);
        check("reset_ferr", o_ferr, 0);
        check("reset_data", o_data, 8'h00);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);

        // Single frame plus latency from stop-bit midpoint to o_vld
        send_byte(8'h55, 1'b1, DIV);
        drain("drain_55");
        lat = int'(vld_cyc - start_cyc);
        n_cmp++;
        if ((2 * lat - (6 + 19 * DIV)) > 2 || (2 * lat - (6 + 19 * DIV)) < -2) begin
            n_bad++;
            $display("FAIL latency: got %0d cycles, expected %0d.5 +-1", lat, 3 + (19 * DIV) / 2);
        end

        // Short low glitch must be rejected, then a real frame
        @(posedge clk);
        #1 i_rx = 1'b0;
        repeat (5) @(posedge clk);
        #1 i_rx = 1'b1;
        repeat (40) @(posedge clk);
        check("glitch_no_pulse", exp_q.size(), 0);
        send_byte(8'hA5, 1'b1, DIV);
        drain("drain_a5");

        // Framing error, long break, recovery
        send_byte(8'hA5, 1'b0, DIV);
        repeat (100) @(posedge clk);
        #1 i_rx = 1'b1;
        repeat (5) @(posedge clk);
        drain("drain_ferr");
        send_byte(8'h3C, 1'b1, DIV);
        drain("drain_3c");

        // Back-to-back frames with no idle gap
        send_byte(8'h00, 1'b1, DIV);
        send_byte(8'hFF, 1'b1, DIV);
        drain("drain_b2b");

        // Reset in the middle of bit 3 of 0x81
        b = 8'h81;
        drive_bit(1'b0, DIV);
        for (int j = 0; j < 3; j++) drive_bit(b[j], DIV);
        @(posedge clk);
        #1 i_rx = b[3];
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        last_good = 8'h00;
        hold_data = 8'h00;
        exp_q.delete();
        @(negedge clk);
        check("midrst_vld", o_vld, 0);
        check("midrst_ferr", o_ferr, 0);
        check("midrst_data", o_data, 8'h00);
        @(posedge clk);
        #1 i_rx = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        check("midrst_no_pulse", exp_q.size(), 0);
        send_byte(8'h7E, 1'b1, DIV);
        drain("drain_7e");

        // Random bytes, bit periods and occasional framing errors
        for (int k = 0; k < 20; k++) begin
            b    = 8'($urandom);
            per  = 24 + $urandom_range(0, 2);
            stop = ($urandom_range(0, 4) != 0);
            send_byte(b, stop, per);
            if (!stop) begin
                @(posedge clk);
                #1 i_rx = 1'b1;
                repeat (2) @(posedge clk);
            end
            repeat ($urandom_range(0, 20)) @(posedge clk);
        end
        drain("drain_random");

        // Every byte value, back-to-back, transmitter period 25/24/26
        for (int i = 0; i < 256; i++) send_byte(8'(i), 1'b1, periods[i % 3]);
        drain("drain_sweep");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
